// File: rtl/led_seq_pkg.sv
// Shared types and CSR map for the LED PIO sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        ROT_L,
        ROT_R,
        COUNT,
        BOUNCE
    } mode_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_SEED   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

endpackage

// File: rtl/led_pio_sequencer_if.sv
// CSR slave port and LED PIO master port of the sequencer as one bundle.
interface led_pio_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [1:0]        pio_address;
    logic              pio_chipselect;
    logic              pio_write_n;
    logic [DATA_W-1:0] pio_writedata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
endinterface

// File: rtl/led_step_timer.sv
// Loadable down-counter; last flags the final cycle of a step interval.
module led_step_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         last
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));
endmodule

// File: rtl/led_pio_sequencer.sv
// Steps an LED pattern through a PIO slave at a CSR-programmed rate.
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PERIOD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [DATA_W-1:0] pio_writedata
);
    state_t              state_q, state_d;
    logic                en_q;
    mode_t               mode_q;
    logic [PERIOD_W-1:0] period_q, eff_period;
    logic [DATA_W-1:0]   seed_q, pattern_q, nxt_pat;
    logic                dir_right_q, nxt_dir;
    logic                wr, stop;
    logic                load_pat, adv, tmr_load, tmr_dec, tmr_last, pio_cs;

    assign wr   = chipselect & ~write_n;
    assign stop = wr && (address == ADDR_CTRL) && !writedata[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= 1'b0;
            mode_q   <= ROT_L;
            period_q <= '0;
            seed_q   <= '0;
        end else if (wr) begin
            case (address)
                ADDR_CTRL: begin
                    en_q   <= writedata[0];
                    mode_q <= mode_t'(writedata[2:1]);
                end
                ADDR_PERIOD: period_q <= PERIOD_W'(writedata);
                ADDR_SEED:   seed_q   <= writedata;
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata[2:0] = {mode_q, en_q};
            ADDR_PERIOD: readdata      = DATA_W'(period_q);
            ADDR_SEED:   readdata      = seed_q;
            default:     readdata      = pattern_q;
        endcase
    end

    assign eff_period = (period_q == '0) ? PERIOD_W'(1) : period_q;

    // Bounce reverses on the edge bit and steps back in the same advance.
    always_comb begin
        nxt_pat = pattern_q;
        nxt_dir = dir_right_q;
        unique case (mode_q)
            ROT_L: nxt_pat = {pattern_q[DATA_W-2:0], pattern_q[DATA_W-1]};
            ROT_R: nxt_pat = {pattern_q[0], pattern_q[DATA_W-1:1]};
            COUNT: nxt_pat = pattern_q + DATA_W'(1);
            BOUNCE: begin
                if (!dir_right_q && pattern_q[DATA_W-1]) begin
                    nxt_dir = 1'b1;
                    nxt_pat = pattern_q >> 1;
                end else if (dir_right_q && pattern_q[0]) begin
                    nxt_dir = 1'b0;
                    nxt_pat = pattern_q << 1;
                end else begin
                    nxt_pat = dir_right_q ? pattern_q >> 1 : pattern_q << 1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q   <= '0;
            dir_right_q <= 1'b0;
        end else if (load_pat) begin
            pattern_q   <= seed_q;
            dir_right_q <= 1'b0;
        end else if (adv) begin
            pattern_q   <= nxt_pat;
            dir_right_q <= nxt_dir;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_pat = 1'b0;
        adv      = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        pio_cs   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en_q && !stop) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_pat = 1'b1;
                state_d  = stop ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                pio_cs   = 1'b1;
                tmr_load = 1'b1;
                state_d  = stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                tmr_dec = 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tmr_last) begin
                    adv     = 1'b1;
                    state_d = S_WRITE;
                end
            end
        endcase
    end

    led_step_timer #(
        .W(PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (tmr_load),
        .value  (eff_period),
        .dec    (tmr_dec),
        .last   (tmr_last)
    );

    assign pio_address    = 2'b00;
    assign pio_chipselect = pio_cs;
    assign pio_write_n    = ~pio_cs;
    assign pio_writedata  = pio_cs ? pattern_q : '0;
endmodule

// File: tb/tb_led_pio_sequencer.sv
// Random and directed sequences checked against a write-schedule model.
module tb_led_pio_sequencer;
    import led_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    led_pio_sequencer_if #(.DATA_W(32)) bus ();

    led_pio_sequencer #(
        .DATA_W  (32),
        .PERIOD_W(32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (bus.address),
        .chipselect    (bus.chipselect),
        .write_n       (bus.write_n),
        .writedata     (bus.writedata),
        .readdata      (bus.readdata),
        .pio_address   (bus.pio_address),
        .pio_chipselect(bus.pio_chipselect),
        .pio_write_n   (bus.pio_write_n),
        .pio_writedata (bus.pio_writedata)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned mon_t[$];
    logic [31:0] mon_d[$];
    always @(negedge clk) begin
        if (bus.pio_chipselect && !bus.pio_write_n) begin
            mon_t.push_back(cyc);
            mon_d.push_back(bus.pio_writedata);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d,
                             output int unsigned en_edge);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        en_edge        = cyc + 1;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1 d = bus.readdata;
        #1 bus.chipselect = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (mon_d.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("wait_writes", 64'(mon_d.size() >= n), 64'd1);
    endtask

    function automatic logic [31:0] step(input int m, input logic [31:0] p,
                                         inout bit right);
        case (m)
            0: return (p << 1) | (p >> 31);
            1: return (p >> 1) | (p << 31);
            2: return p + 32'd1;
            default: begin
                if (!right && p[31]) begin
                    right = 1'b1;
                    return p >> 1;
                end
                if (right && p[0]) begin
                    right = 1'b0;
                    return p << 1;
                end
                return right ? p >> 1 : p << 1;
            end
        endcase
    endfunction

    // Write k lands edge n0+2+k*(eff+1) with the seed stepped k times.
    task automatic verify(input int m, input logic [31:0] seed,
                          input int unsigned n0, input int eff);
        logic [31:0] p = seed;
        bit r = 1'b0;
        for (int k = 0; k < mon_d.size(); k++) begin
            check("pio_time", 64'(mon_t[k]), 64'(n0 + 2 + k * (eff + 1)));
            check("pio_data", 64'(mon_d[k]), 64'(p));
            p = step(m, p, r);
        end
    endtask

    task automatic run_seq(input int m, input logic [31:0] seed,
                           input int per, input int n, input bit set_seed);
        int unsigned n0, ns, tmp;
        int eff;
        logic [31:0] st;
        eff = (per == 0) ? 1 : per;
        mon_t.delete();
        mon_d.delete();
        csr_write(ADDR_PERIOD, 32'(per), tmp);
        if (set_seed) csr_write(ADDR_SEED, seed, tmp);
        csr_write(ADDR_CTRL, 32'(m * 2 + 1), n0);
        wait_writes(n, (eff + 1) * (n + 2) + 10);
        csr_write(ADDR_CTRL, 32'(m * 2), tmp);
        ns = mon_d.size();
        repeat (2 * eff + 6) @(negedge clk);
        #1;
        check("no_write_after_stop", 64'(mon_d.size()), 64'(ns));
        verify(m, seed, n0, eff);
        csr_read(ADDR_STATUS, st);
        if (ns > 0) check("status_hold", 64'(st), 64'(mon_d[ns-1]));
    endtask

    initial begin
        int unsigned n0, tmp, nb;
        logic [31:0] rd;
        int unsigned exp_t[4];
        logic [31:0] exp_d[4];

        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        check("rst_pio_cs", 64'(bus.pio_chipselect), 64'd0);
        check("rst_pio_wn", 64'(bus.pio_write_n), 64'd1);
        check("rst_pio_addr", 64'(bus.pio_address), 64'd0);
        check("rst_pio_data", 64'(bus.pio_writedata), 64'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check("rst_csr", 64'(rd), 64'd0);
        end

        csr_write(ADDR_CTRL, 32'hFFFF_FFF8, tmp);
        csr_read(ADDR_CTRL, rd);
        check("ctrl_unused_bits", 64'(rd), 64'd0);
        csr_write(ADDR_CTRL, 32'h6, tmp);
        csr_read(ADDR_CTRL, rd);
        check("ctrl_mode", 64'(rd), 64'h6);
        csr_write(ADDR_PERIOD, 32'h1234, tmp);
        csr_read(ADDR_PERIOD, rd);
        check("period_rw", 64'(rd), 64'h1234);
        csr_write(ADDR_SEED, 32'hA5A5_0001, tmp);
        csr_read(ADDR_SEED, rd);
        check("seed_rw", 64'(rd), 64'hA5A5_0001);
        csr_write(ADDR_STATUS, 32'hDEAD, tmp);
        csr_read(ADDR_STATUS, rd);
        check("status_ro", 64'(rd), 64'd0);
        check("idle_no_write", 64'(mon_d.size()), 64'd0);

        run_seq(0, 32'h1, 3, 4, 1'b1);
        run_seq(0, 32'h1, 3, 2, 1'b0);
        run_seq(2, 32'hFFFF_FFFE, 0, 3, 1'b1);
        run_seq(3, 32'h4000_0000, 1, 4, 1'b1);
        run_seq(3, 32'h0000_0002, 1, 4, 1'b1);
        run_seq(0, 32'h0, 2, 3, 1'b1);
        run_seq(3, 32'h0, 1, 3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_seq(int'($urandom_range(0, 3)), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(3, 6)),
                    1'b1);
        end

        mon_t.delete();
        mon_d.delete();
        csr_write(ADDR_PERIOD, 32'd5, tmp);
        csr_write(ADDR_SEED, 32'h1, tmp);
        csr_write(ADDR_CTRL, 32'h1, n0);
        wait_writes(1, 20);
        repeat (2) @(negedge clk);
        csr_write(ADDR_PERIOD, 32'd2, tmp);
        wait_writes(4, 40);
        csr_write(ADDR_CTRL, 32'h0, tmp);
        repeat (10) @(negedge clk);
        #1;
        check("period_chg_count", 64'(mon_d.size()), 64'd4);
        exp_t = '{n0 + 2, n0 + 8, n0 + 11, n0 + 14};
        exp_d = '{32'h1, 32'h2, 32'h4, 32'h8};
        for (int k = 0; k < 4 && k < mon_d.size(); k++) begin
            check("period_chg_time", 64'(mon_t[k]), 64'(exp_t[k]));
            check("period_chg_data", 64'(mon_d[k]), 64'(exp_d[k]));
        end

        mon_t.delete();
        mon_d.delete();
        csr_write(ADDR_PERIOD, 32'd2, tmp);
        csr_write(ADDR_SEED, 32'h5, tmp);
        csr_write(ADDR_CTRL, 32'h1, n0);
        wait_writes(1, 20);
        check("pre_rst_cs", 64'(bus.pio_chipselect), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_cs", 64'(bus.pio_chipselect), 64'd0);
        check("mid_rst_wn", 64'(bus.pio_write_n), 64'd1);
        check("mid_rst_data", 64'(bus.pio_writedata), 64'd0);
        nb = mon_d.size();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check("post_rst_csr", 64'(rd), 64'd0);
        end
        repeat (20) @(negedge clk);
        #1;
        check("post_rst_idle", 64'(mon_d.size()), 64'(nb));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
